// File: rtl/tinyqv_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-byte holding
// register with valid/ready pop, framing-error pulse and sticky overrun flag.
module tinyqv_uart_rx #(
  parameter int CLKS_PER_BIT = 556,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [1:0]       sync_q;
  logic             rxd_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             line_idle_q, line_idle_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             stop_ok;
  logic             ovr_set;
  logic             pop;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
    end
  end

  assign rxd_s = sync_q[1];
  assign pop   = rx_valid_q & rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      line_idle_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      line_idle_q <= line_idle_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    line_idle_d = line_idle_q | rxd_s;
    frame_err_d = 1'b0;
    stop_ok     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A break keeps line_idle low, so a held-low line cannot restart a frame.
        if (!rxd_s && line_idle_q) begin
          state_d     = S_START;
          line_idle_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rxd_s) begin
            stop_ok = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A same-cycle pop frees the slot, so the new byte replaces the old one.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_set    = 1'b0;
    if (stop_ok) begin
      if (!rx_valid_q || pop) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (pop) begin
      rx_valid_d = 1'b0;
    end
    overrun_d = overrun_clr ? 1'b0 : (overrun_q | ovr_set);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tinyqv_uart_rx.sv
// Bench for tinyqv_uart_rx: directed frames, expected bytes queued at send time
// and matched by a monitor whenever the holding register loads a new byte.
module tb_tinyqv_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fe_seen = 0;
  int fe_exp = 0;
  int rise_cyc = -1;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_pop = 1'b0;
  logic prev_fe = 1'b0;

  tinyqv_uart_rx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(C);
    end
    uart_rxd = stop_bit;
    tick(C);
    uart_rxd = 1'b1;
  endtask

  // New byte presented: valid rose, or a pop and a load coincided.
  always @(negedge clk) begin
    if (rst_n && rx_valid && (!prev_valid || prev_pop)) begin
      checks++;
      rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          failures++;
          $display("FAIL rx_byte: got 0x%0h expected 0x%0h", rx_data, e);
        end
      end
    end
    if (frame_err === 1'b1) begin
      fe_seen++;
      if (prev_fe) begin
        checks++;
        failures++;
        $display("FAIL frame_err_width: got 2+ cycles expected 1");
      end
    end
    prev_fe    = (frame_err === 1'b1);
    prev_valid = rx_valid;
    prev_pop   = rx_valid & rx_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int lat;
    tick(3);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(4);

    // 1: 0xA5, no pop; rxd_s falls two edges after the line does
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    tick(2);
    lat = rise_cyc - (t0 + 2);
    checks++;
    if (lat < H + 9 * C || lat > H + 9 * C + 1) begin
      failures++;
      $display("FAIL latency: got %0d expected %0d..%0d", lat, H + 9 * C, H + 9 * C + 1);
    end
    check("t1_valid", rx_valid, 1);
    check("t1_fe", fe_seen, 0);
    check("t1_overrun", overrun, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    check("pop_valid", rx_valid, 0);

    // 2: short low glitch
    uart_rxd = 1'b0;
    tick(4);
    @(negedge clk);
    check("glitch_busy", busy, 1);
    tick(1);
    uart_rxd = 1'b1;
    tick(2 * C);
    check("glitch_idle", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_fe", fe_seen, 0);

    // 3: framing error
    fe_exp++;
    send_byte(8'h3C, 1'b0);
    tick(C);
    check("t3_fe", fe_seen, fe_exp);
    check("t3_valid", rx_valid, 0);
    check("t3_overrun", overrun, 0);

    // 4: back-to-back with no pop
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(2);
    check("t4_data", rx_data, 8'h11);
    check("t4_overrun", overrun, 1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    tick(1);
    check("t4_clr", overrun, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    check("t4_pop", rx_valid, 0);

    // 5: pop on the completion cycle of the next byte
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    tick(2);
    exp_q.push_back(8'h66);
    fork
      send_byte(8'h66, 1'b1);
      begin
        tick(H + 9 * C + 2);
        rx_ready = 1'b1;
        @(negedge clk);
        check("t5_old", rx_data, 8'h55);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        @(negedge clk);
        check("t5_valid", rx_valid, 1);
        check("t5_new", rx_data, 8'h66);
      end
    join
    tick(2);
    check("t5_overrun", overrun, 0);

    // 6: reset in the middle of DATA of 0xFF, holding register full
    uart_rxd = 1'b0;
    tick(C);
    uart_rxd = 1'b1;
    tick(3 * C);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_valid", rx_valid, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2 * C);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    tick(2);
    check("t6_valid2", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);

    // Break: one error pulse, then no restart while the line stays low
    fe_exp++;
    uart_rxd = 1'b0;
    tick(12 * C);
    check("brk_busy", busy, 0);
    uart_rxd = 1'b1;
    tick(2 * C);
    check("brk_fe", fe_seen, fe_exp);
    check("brk_valid", rx_valid, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
